irig_time_keeper: RTL and testbench
===================================

Name: irig_time_keeper

Overview:
- Downstream stage of the IRIG-B BCD decoder.
- Consumes decoded sec/min/hr/day frames (bcd_valid) and the per-second pps strobe.
- Maintains a free-running time-of-day plus a sub-second clock counter aligned to pps.
- Flywheels through missing pps; reports lock, holdover and frame-consistency status to the rest of the design.

Parameters:
- SUBSEC_W, 32, width of the sub-second clock counter and of clk_per_sec.
- HOLDOVER_SECS, 8, number of consecutive missing pps tolerated before dropping time_valid.
- TOL_W, 16, width of the pps tolerance input.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- clk_per_sec  in  SUBSEC_W  clocks per second (runtime, e.g. 100000000).
- pps_tol  in  TOL_W  accepted pps early/late window, in clocks.
- leap_year  in  1  selects day wrap: 1 = after 366, 0 = after 365.
- sec  in  6  decoded seconds, binary.
- min  in  6  decoded minutes.
- hr  in  5  decoded hours.
- day  in  9  decoded day-of-year.
- bcd_valid  in  1  one-cycle strobe; fields valid.
- pps  in  1  one-cycle second strobe from the decoder.
- t_sec  out  6  running seconds.
- t_min  out  6  running minutes.
- t_hr  out  5  running hours.
- t_day  out  9  running day-of-year.
- subsec  out  SUBSEC_W  clocks since the last second boundary.
- tick  out  1  one-cycle pulse at each second boundary (real or flywheel).
- time_valid  out  1  running time is trustworthy.
- holdover  out  1  running on flywheel.
- mismatch  out  1  one-cycle pulse: a decoded frame disagreed with the running time.
- bad_frame  out  1  one-cycle pulse: a decoded frame failed the range check.

Behaviour:
- Reset values: all time outputs 0, except t_day = 1. subsec=0, tick=0, time_valid=0, holdover=0, mismatch=0, bad_frame=0. State UNSYNC, miss counter 0, pending empty.
- Range check on bcd_valid:
  - Limits: sec<=59, min<=59, hr<=23, 1<=day<=365+leap_year.
  - On failure: pulse bad_frame the next cycle and discard the frame.
- Frame semantics: a frame describes the second that began at the pps preceding it. On a valid frame, store pending = frame + 1 s, with carries sec→min→hr→day and day wrapping to 1. Set pending_full.
- States:
  - UNSYNC: subsec counts and wraps at clk_per_sec-1; tick is not asserted. A valid frame moves to ARMED.
  - ARMED: on pps, load pending into t_*, set subsec=0, pulse tick, clear pending_full, set time_valid=1, go to LOCKED. A new valid frame before the pps overwrites pending.
  - LOCKED:
    - pps accepted when subsec >= clk_per_sec-1-pps_tol: increment t_*, set subsec=0, pulse tick, clear miss counter.
    - pps earlier than the window is ignored.
    - If subsec reaches clk_per_sec-1+pps_tol with no pps: flywheel tick (increment t_*, pulse tick), set subsec=pps_tol, miss counter +1, go to HOLDOVER.
    - Valid frame compared with current t_*: if equal, no action; if different, pulse mismatch, store pending, and reload at the next accepted pps.
  - HOLDOVER:
    - holdover=1. A flywheel tick fires every time subsec reaches clk_per_sec-1; each one increments the miss counter.
    - An accepted pps (any subsec) realigns subsec to 0, pulses tick, increments t_*, clears the miss counter and returns to LOCKED.
    - When the miss counter exceeds HOLDOVER_SECS: time_valid=0, holdover=0, go to UNSYNC.
- Simultaneous pps and bcd_valid: the pps is applied first using pre-existing pending/t_*. The frame is then captured as new pending and is not compared.
- Latency: t_* and tick update in the cycle after pps; mismatch and bad_frame appear 1 cycle after bcd_valid.
- Width rule: subsec comparisons are done at SUBSEC_W+1 bits so clk_per_sec+pps_tol cannot overflow.
- clk_per_sec=0 is illegal; behaviour is undefined.

Optional Feature:
- Macro IRIG_TS_LATCH_EN.
- When defined, adds ports:
  - ts_strobe  in  1
  - ts_sec  out  6
  - ts_min  out  6
  - ts_hr  out  5
  - ts_day  out  9
  - ts_subsec  out  SUBSEC_W
  - ts_valid  out  1
- On ts_strobe, capture the running time and subsec one cycle later; ts_valid pulses for one cycle.
- If ts_strobe coincides with tick, capture the post-increment time with subsec=0.
- When not defined, none of these ports or registers exist.

Decomposition:
- Package irig_pkg holds:
  - state encoding: UNSYNC, ARMED, LOCKED, HOLDOVER;
  - field widths: 6/6/5/9;
  - limit constants: 59, 23, 365/366;
  - a time-of-day struct typedef.
- Sub-module irig_tod_incr: adds 1 s with full carry and leap-aware day wrap. It is instanced twice, for the pending time and the running time.

Test Plan:
- clk_per_sec=1000, pps_tol=5; frame 12:34:56 day 100, then pps → tick, t=12:34:57 day 100, time_valid=1, subsec=0.
- Frame 23:59:59 day 365, leap_year=0, then pps → t=00:00:00 day 1; same frame with leap_year=1 → day 366.
- Locked, then pps removed for 3 s → holdover=1, 3 ticks 1000 clocks apart, time advances by 3; pps restored → holdover=0, subsec realigned to 0.
- Locked with HOLDOVER_SECS=8, pps removed for 10 s → time_valid drops after the 9th flywheel tick, state UNSYNC.
- Locked at 10:00:05, frame reports 10:00:09 → mismatch pulse; next pps → t=10:00:10.
- Frame sec=61 → bad_frame pulse, state unchanged. Early pps at subsec=500 → ignored, no tick.

Source files
------------

// File: rtl/irig_pkg.sv
// Shared definitions for the IRIG-B time keeper: FSM states, time-of-day
// field widths, range limits and the packed time-of-day record.
package irig_pkg;

    localparam int SEC_W = 6;
    localparam int MIN_W = 6;
    localparam int HR_W  = 5;
    localparam int DAY_W = 9;

    localparam logic [SEC_W-1:0] SEC_MAX      = SEC_W'(59);
    localparam logic [MIN_W-1:0] MIN_MAX      = MIN_W'(59);
    localparam logic [HR_W-1:0]  HR_MAX       = HR_W'(23);
    localparam logic [DAY_W-1:0] DAY_MAX_NORM = DAY_W'(365);
    localparam logic [DAY_W-1:0] DAY_MAX_LEAP = DAY_W'(366);

    typedef enum logic [1:0] {
        UNSYNC,
        ARMED,
        LOCKED,
        HOLDOVER
    } state_e;

    typedef struct packed {
        logic [DAY_W-1:0] day;
        logic [HR_W-1:0]  hr;
        logic [MIN_W-1:0] min;
        logic [SEC_W-1:0] sec;
    } tod_t;

    localparam tod_t TOD_RESET = '{day: DAY_W'(1), hr: '0, min: '0, sec: '0};

    function automatic logic [DAY_W-1:0] day_limit(input logic leap);
        return leap ? DAY_MAX_LEAP : DAY_MAX_NORM;
    endfunction

    function automatic logic tod_in_range(input tod_t t, input logic leap);
        return (t.sec <= SEC_MAX) && (t.min <= MIN_MAX) && (t.hr <= HR_MAX) &&
               (t.day != '0) && (t.day <= day_limit(leap));
    endfunction

endpackage

// File: rtl/irig_tod_incr.sv
// Combinational +1 second on a time-of-day record: carries sec -> min -> hr
// -> day, and the day wraps back to 1 after 365 or 366 depending on leap_i.
module irig_tod_incr
    import irig_pkg::*;
(
    input  tod_t tod_i,
    input  logic leap_i,
    output tod_t tod_o
);

    // Cascaded carry chain; each field only rolls when all lower fields roll.
    // NOTE: every output gets a default before the branches so no latch is inferred.
    always_comb begin
        tod_o = tod_i;
        if (tod_i.sec >= SEC_MAX) begin
            tod_o.sec = '0;
            if (tod_i.min >= MIN_MAX) begin
                tod_o.min = '0;
                if (tod_i.hr >= HR_MAX) begin
                    tod_o.hr = '0;
                    if (tod_i.day >= day_limit(leap_i)) begin
                        tod_o.day = DAY_W'(1);
                    end else begin
                        tod_o.day = tod_i.day + DAY_W'(1);
                    end
                end else begin
                    tod_o.hr = tod_i.hr + HR_W'(1);
                end
            end else begin
                tod_o.min = tod_i.min + MIN_W'(1);
            end
        end else begin
            tod_o.sec = tod_i.sec + SEC_W'(1);
        end
    end

endmodule

// File: rtl/irig_time_keeper.sv
// IRIG-B time keeper: turns decoded BCD frames plus the pps strobe into a
// free-running time-of-day with a pps-aligned sub-second counter, flywheels
// through missing pps and reports lock/holdover/frame status.
// Optional timestamp latch port set is enabled with `define IRIG_TS_LATCH_EN.
module irig_time_keeper
    import irig_pkg::*;
#(
    parameter int SUBSEC_W      = 32,
    parameter int HOLDOVER_SECS = 8,
    parameter int TOL_W         = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SUBSEC_W-1:0] clk_per_sec,
    input  logic [TOL_W-1:0]    pps_tol,
    input  logic                leap_year,
    input  logic [SEC_W-1:0]    sec,
    input  logic [MIN_W-1:0]    min,
    input  logic [HR_W-1:0]     hr,
    input  logic [DAY_W-1:0]    day,
    input  logic                bcd_valid,
    input  logic                pps,
    output logic [SEC_W-1:0]    t_sec,
    output logic [MIN_W-1:0]    t_min,
    output logic [HR_W-1:0]     t_hr,
    output logic [DAY_W-1:0]    t_day,
    output logic [SUBSEC_W-1:0] subsec,
    output logic                tick,
    output logic                time_valid,
    output logic                holdover,
    output logic                mismatch,
    output logic                bad_frame
`ifdef IRIG_TS_LATCH_EN
    ,
    input  logic                ts_strobe,
    output logic [SEC_W-1:0]    ts_sec,
    output logic [MIN_W-1:0]    ts_min,
    output logic [HR_W-1:0]     ts_hr,
    output logic [DAY_W-1:0]    ts_day,
    output logic [SUBSEC_W-1:0] ts_subsec,
    output logic                ts_valid
`endif
);

    localparam int EXT_W  = SUBSEC_W + 1;
    localparam int MISS_W = $clog2(HOLDOVER_SECS + 2);
    localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(HOLDOVER_SECS);

    state_e              state_q, state_d;
    tod_t                t_q, t_d, pend_q, pend_d;
    logic                pend_full_q, pend_full_d;
    logic [SUBSEC_W-1:0] subsec_q, subsec_d;
    logic [MISS_W-1:0]   miss_q, miss_d;
    logic                tick_q, tick_d;
    logic                time_valid_q, time_valid_d;
    logic                mismatch_q, mismatch_d;
    logic                bad_frame_q, bad_frame_d;

    tod_t frame, frame_inc, t_inc;
    logic frame_ok;
    logic pps_taken;

    // Sub-second thresholds carried one bit wider so cps-1+tol never wraps.
    logic [EXT_W-1:0] sub_x, cps_m1_x, tol_x;
    logic             in_window, lock_limit, sec_end;

    assign frame    = {day, hr, min, sec};
    assign frame_ok = tod_in_range(frame, leap_year);

    assign sub_x      = {1'b0, subsec_q};
    assign cps_m1_x   = {1'b0, clk_per_sec} - EXT_W'(1);
    assign tol_x      = EXT_W'(pps_tol);
    assign in_window  = (sub_x + tol_x) >= cps_m1_x;
    assign lock_limit = sub_x >= (cps_m1_x + tol_x);
    assign sec_end    = sub_x >= cps_m1_x;

    // A frame names the second that began at the previous pps, so pending is frame+1.
    irig_tod_incr u_pend_incr (
        .tod_i  (frame),
        .leap_i (leap_year),
        .tod_o  (frame_inc)
    );

    irig_tod_incr u_tod_incr (
        .tod_i  (t_q),
        .leap_i (leap_year),
        .tod_o  (t_inc)
    );

    // Next-state logic: pps/flywheel handling first, then frame capture or compare.
    always_comb begin
        state_d      = state_q;
        t_d          = t_q;
        pend_d       = pend_q;
        pend_full_d  = pend_full_q;
        subsec_d     = subsec_q + SUBSEC_W'(1);
        miss_d       = miss_q;
        tick_d       = 1'b0;
        time_valid_d = time_valid_q;
        mismatch_d   = 1'b0;
        bad_frame_d  = bcd_valid && !frame_ok;
        pps_taken    = 1'b0;

        case (state_q)
            UNSYNC: begin
                if (sec_end) subsec_d = '0;
            end
            ARMED: begin
                if (sec_end) subsec_d = '0;
                if (pps) begin
                    t_d          = pend_q;
                    subsec_d     = '0;
                    tick_d       = 1'b1;
                    pend_full_d  = 1'b0;
                    miss_d       = '0;
                    time_valid_d = 1'b1;
                    state_d      = LOCKED;
                    pps_taken    = 1'b1;
                end
            end
            LOCKED: begin
                if (pps && in_window) begin
                    t_d         = pend_full_q ? pend_q : t_inc;
                    subsec_d    = '0;
                    tick_d      = 1'b1;
                    pend_full_d = 1'b0;
                    miss_d      = '0;
                    pps_taken   = 1'b1;
                end else if (lock_limit) begin
                    t_d      = t_inc;
                    subsec_d = SUBSEC_W'(pps_tol);
                    tick_d   = 1'b1;
                    miss_d   = miss_q + MISS_W'(1);
                    state_d  = HOLDOVER;
                end
            end
            HOLDOVER: begin
                if (miss_q > MISS_LIMIT) begin
                    time_valid_d = 1'b0;
                    pend_full_d  = 1'b0;
                    miss_d       = '0;
                    state_d      = UNSYNC;
                end else if (pps) begin
                    t_d         = pend_full_q ? pend_q : t_inc;
                    subsec_d    = '0;
                    tick_d      = 1'b1;
                    pend_full_d = 1'b0;
                    miss_d      = '0;
                    state_d     = LOCKED;
                    pps_taken   = 1'b1;
                end else if (sec_end) begin
                    t_d      = t_inc;
                    subsec_d = '0;
                    tick_d   = 1'b1;
                    miss_d   = miss_q + MISS_W'(1);
                end
            end
            default: state_d = UNSYNC;
        endcase

        // Frames seen while running are checked against the live time; a frame
        // that coincides with an applied pps just becomes the new pending.
        if (bcd_valid && frame_ok) begin
            if (state_q == UNSYNC || state_q == ARMED || pps_taken) begin
                pend_d      = frame_inc;
                pend_full_d = 1'b1;
                if (state_q == UNSYNC) state_d = ARMED;
            end else if (frame != t_q) begin
                mismatch_d  = 1'b1;
                pend_d      = frame_inc;
                pend_full_d = 1'b1;
            end
        end
    end

    // State and output registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= UNSYNC;
            t_q          <= TOD_RESET;
            pend_q       <= TOD_RESET;
            pend_full_q  <= 1'b0;
            subsec_q     <= '0;
            miss_q       <= '0;
            tick_q       <= 1'b0;
            time_valid_q <= 1'b0;
            mismatch_q   <= 1'b0;
            bad_frame_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            t_q          <= t_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
            subsec_q     <= subsec_d;
            miss_q       <= miss_d;
            tick_q       <= tick_d;
            time_valid_q <= time_valid_d;
            mismatch_q   <= mismatch_d;
            bad_frame_q  <= bad_frame_d;
        end
    end

    assign t_sec      = t_q.sec;
    assign t_min      = t_q.min;
    assign t_hr       = t_q.hr;
    assign t_day      = t_q.day;
    assign subsec     = subsec_q;
    assign tick       = tick_q;
    assign time_valid = time_valid_q;
    assign holdover   = (state_q == HOLDOVER);
    assign mismatch   = mismatch_q;
    assign bad_frame  = bad_frame_q;

`ifdef IRIG_TS_LATCH_EN
    tod_t                ts_q;
    logic [SUBSEC_W-1:0] ts_subsec_q;
    logic                ts_valid_q;

    // Snapshot the running time on ts_strobe; a strobe on a tick cycle reads subsec as 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q        <= TOD_RESET;
            ts_subsec_q <= '0;
            ts_valid_q  <= 1'b0;
        end else begin
            ts_valid_q <= ts_strobe;
            if (ts_strobe) begin
                ts_q        <= t_q;
                ts_subsec_q <= tick_q ? '0 : subsec_q;
            end
        end
    end

    assign ts_sec    = ts_q.sec;
    assign ts_min    = ts_q.min;
    assign ts_hr     = ts_q.hr;
    assign ts_day    = ts_q.day;
    assign ts_subsec = ts_subsec_q;
    assign ts_valid  = ts_valid_q;
`endif

endmodule

// File: tb/tb_irig_time_keeper.sv
// Directed bench for irig_time_keeper with clk_per_sec=1000, pps_tol=5.
module tb_irig_time_keeper;

    localparam int SUBSEC_W      = 32;
    localparam int TOL_W         = 16;
    localparam int HOLDOVER_SECS = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [SUBSEC_W-1:0] clk_per_sec = 32'd1000;
    logic [TOL_W-1:0]    pps_tol = 16'd5;
    logic                leap_year = 1'b0;
    logic [5:0]          sec = '0;
    logic [5:0]          min = '0;
    logic [4:0]          hr = '0;
    logic [8:0]          day = '0;
    logic                bcd_valid = 1'b0;
    logic                pps = 1'b0;
    logic [5:0]          t_sec;
    logic [5:0]          t_min;
    logic [4:0]          t_hr;
    logic [8:0]          t_day;
    logic [SUBSEC_W-1:0] subsec;
    logic                tick, time_valid, holdover, mismatch, bad_frame;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    irig_time_keeper #(
        .SUBSEC_W      (SUBSEC_W),
        .HOLDOVER_SECS (HOLDOVER_SECS),
        .TOL_W         (TOL_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_per_sec (clk_per_sec),
        .pps_tol     (pps_tol),
        .leap_year   (leap_year),
        .sec         (sec),
        .min         (min),
        .hr          (hr),
        .day         (day),
        .bcd_valid   (bcd_valid),
        .pps         (pps),
        .t_sec       (t_sec),
        .t_min       (t_min),
        .t_hr        (t_hr),
        .t_day       (t_day),
        .subsec      (subsec),
        .tick        (tick),
        .time_valid  (time_valid),
        .holdover    (holdover),
        .mismatch    (mismatch),
        .bad_frame   (bad_frame)
    );

    logic [25:0] t_now;
    assign t_now = {t_hr, t_min, t_sec, t_day};

    function automatic logic [25:0] tod(input int h, input int m, input int s, input int d);
        return {5'(h), 6'(m), 6'(s), 9'(d)};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_pps();
        pps = 1'b1;
        step(1);
        pps = 1'b0;
    endtask

    task automatic send_frame(input int s, input int m, input int h, input int d);
        sec = 6'(s); min = 6'(m); hr = 5'(h); day = 9'(d);
        bcd_valid = 1'b1;
        step(1);
        bcd_valid = 1'b0;
    endtask

    task automatic wait_subsec(input int target);
        int n = 0;
        while (subsec !== SUBSEC_W'(target) && n < 2100) begin
            step(1);
            n++;
        end
        if (subsec !== SUBSEC_W'(target)) begin
            n_checks++;
            $display("FAIL wait_subsec timeout: subsec=%0d wanted %0d", subsec, target);
        end
    endtask

    task automatic wait_tick(input int budget, output bit seen, output int cycles);
        seen = 1'b0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            step(1);
            cycles++;
            if (tick === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(3);
        n_checks++; if (t_now !== tod(0, 0, 0, 1)) $display("FAIL reset_time: got %h exp %h", t_now, tod(0, 0, 0, 1)); else n_pass++;
        n_checks++; if (subsec !== '0) $display("FAIL reset_subsec: got %0d exp 0", subsec); else n_pass++;
        n_checks++; if ({tick, time_valid, holdover, mismatch, bad_frame} !== 5'b0)
            $display("FAIL reset_flags: got %b exp 00000", {tick, time_valid, holdover, mismatch, bad_frame}); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_first_lock();
        send_frame(56, 34, 12, 100);
        n_checks++; if ({tick, time_valid, mismatch, bad_frame} !== 4'b0)
            $display("FAIL armed_flags: got %b exp 0000", {tick, time_valid, mismatch, bad_frame}); else n_pass++;
        pulse_pps();
        n_checks++; if (tick !== 1'b1) $display("FAIL lock_tick: got %b exp 1", tick); else n_pass++;
        n_checks++; if (t_now !== tod(12, 34, 57, 100)) $display("FAIL lock_time: got %h exp %h", t_now, tod(12, 34, 57, 100)); else n_pass++;
        n_checks++; if (time_valid !== 1'b1 || subsec !== '0)
            $display("FAIL lock_valid_subsec: got tv=%b subsec=%0d exp tv=1 subsec=0", time_valid, subsec); else n_pass++;
        step(1);
        n_checks++; if (tick !== 1'b0 || subsec !== SUBSEC_W'(1))
            $display("FAIL lock_after: got tick=%b subsec=%0d exp tick=0 subsec=1", tick, subsec); else n_pass++;
    endtask

    task automatic test_pps_window();
        wait_subsec(500);
        pulse_pps();
        n_checks++; if (tick !== 1'b0 || subsec !== SUBSEC_W'(501))
            $display("FAIL early_pps: got tick=%b subsec=%0d exp tick=0 subsec=501", tick, subsec); else n_pass++;
        n_checks++; if (t_now !== tod(12, 34, 57, 100)) $display("FAIL early_time: got %h exp %h", t_now, tod(12, 34, 57, 100)); else n_pass++;
        wait_subsec(999);
        pulse_pps();
        n_checks++; if (tick !== 1'b1 || t_now !== tod(12, 34, 58, 100))
            $display("FAIL pps_999: got tick=%b t=%h exp tick=1 t=%h", tick, t_now, tod(12, 34, 58, 100)); else n_pass++;
        wait_subsec(993);
        pulse_pps();
        n_checks++; if (tick !== 1'b0) $display("FAIL pps_993_rejected: got tick=%b exp 0", tick); else n_pass++;
        pulse_pps();
        n_checks++; if (tick !== 1'b1 || t_now !== tod(12, 34, 59, 100))
            $display("FAIL pps_994_accepted: got tick=%b t=%h exp tick=1 t=%h", tick, t_now, tod(12, 34, 59, 100)); else n_pass++;
        wait_subsec(1002);
        pulse_pps();
        n_checks++; if (tick !== 1'b1 || t_now !== tod(12, 35, 0, 100) || holdover !== 1'b0)
            $display("FAIL pps_1002_late: got tick=%b t=%h ho=%b exp tick=1 t=%h ho=0", tick, t_now, holdover, tod(12, 35, 0, 100)); else n_pass++;
    endtask

    task automatic test_holdover_recover();
        bit seen;
        int cyc;
        wait_tick(1100, seen, cyc);
        n_checks++; if (!seen || holdover !== 1'b1 || subsec !== SUBSEC_W'(5))
            $display("FAIL fly1: got seen=%b ho=%b subsec=%0d exp seen=1 ho=1 subsec=5", seen, holdover, subsec); else n_pass++;
        n_checks++; if (t_now !== tod(12, 35, 1, 100)) $display("FAIL fly1_time: got %h exp %h", t_now, tod(12, 35, 1, 100)); else n_pass++;
        wait_tick(1100, seen, cyc);
        n_checks++; if (!seen || t_now !== tod(12, 35, 2, 100))
            $display("FAIL fly2: got seen=%b t=%h exp seen=1 t=%h", seen, t_now, tod(12, 35, 2, 100)); else n_pass++;
        wait_tick(1100, seen, cyc);
        n_checks++; if (!seen || cyc != 1000)
            $display("FAIL fly3_spacing: got seen=%b cycles=%0d exp seen=1 cycles=1000", seen, cyc); else n_pass++;
        n_checks++; if (t_now !== tod(12, 35, 3, 100) || time_valid !== 1'b1)
            $display("FAIL fly3_time: got t=%h tv=%b exp t=%h tv=1", t_now, time_valid, tod(12, 35, 3, 100)); else n_pass++;
        wait_subsec(300);
        pulse_pps();
        n_checks++; if (tick !== 1'b1 || holdover !== 1'b0 || subsec !== '0 || t_now !== tod(12, 35, 4, 100))
            $display("FAIL recover: got tick=%b ho=%b subsec=%0d t=%h exp 1 0 0 %h", tick, holdover, subsec, t_now, tod(12, 35, 4, 100)); else n_pass++;
    endtask

    task automatic test_mismatch();
        send_frame(4, 0, 10, 50);
        n_checks++; if (mismatch !== 1'b1 || bad_frame !== 1'b0)
            $display("FAIL mm1: got mm=%b bad=%b exp mm=1 bad=0", mismatch, bad_frame); else n_pass++;
        step(1);
        n_checks++; if (mismatch !== 1'b0) $display("FAIL mm1_pulse: got %b exp 0", mismatch); else n_pass++;
        wait_subsec(999);
        pulse_pps();
        n_checks++; if (t_now !== tod(10, 0, 5, 50)) $display("FAIL mm1_reload: got %h exp %h", t_now, tod(10, 0, 5, 50)); else n_pass++;
        send_frame(9, 0, 10, 50);
        n_checks++; if (mismatch !== 1'b1) $display("FAIL mm2: got %b exp 1", mismatch); else n_pass++;
        wait_subsec(999);
        pulse_pps();
        n_checks++; if (tick !== 1'b1 || t_now !== tod(10, 0, 10, 50))
            $display("FAIL mm2_reload: got tick=%b t=%h exp tick=1 t=%h", tick, t_now, tod(10, 0, 10, 50)); else n_pass++;
        send_frame(10, 0, 10, 50);
        n_checks++; if (mismatch !== 1'b0) $display("FAIL equal_frame: got mm=%b exp 0", mismatch); else n_pass++;
    endtask

    task automatic test_bad_frame();
        int vec [5][4] = '{'{61, 0, 10, 50}, '{0, 60, 10, 50}, '{0, 0, 24, 50}, '{0, 0, 10, 0}, '{0, 0, 10, 366}};
        leap_year = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_frame(vec[i][0], vec[i][1], vec[i][2], vec[i][3]);
            n_checks++; if (bad_frame !== 1'b1 || mismatch !== 1'b0)
                $display("FAIL bad_frame_%0d: got bad=%b mm=%b exp bad=1 mm=0", i, bad_frame, mismatch); else n_pass++;
        end
        step(1);
        n_checks++; if (bad_frame !== 1'b0) $display("FAIL bad_frame_pulse: got %b exp 0", bad_frame); else n_pass++;
        wait_subsec(999);
        pulse_pps();
        n_checks++; if (t_now !== tod(10, 0, 11, 50)) $display("FAIL bad_frame_discard: got %h exp %h", t_now, tod(10, 0, 11, 50)); else n_pass++;
    endtask

    task automatic test_simultaneous();
        wait_subsec(999);
        sec = 6'd3; min = 6'd2; hr = 5'd1; day = 9'd5;
        bcd_valid = 1'b1;
        pps = 1'b1;
        step(1);
        bcd_valid = 1'b0;
        pps = 1'b0;
        n_checks++; if (tick !== 1'b1 || mismatch !== 1'b0 || t_now !== tod(10, 0, 12, 50))
            $display("FAIL simul_pps_first: got tick=%b mm=%b t=%h exp 1 0 %h", tick, mismatch, t_now, tod(10, 0, 12, 50)); else n_pass++;
        wait_subsec(999);
        pulse_pps();
        n_checks++; if (t_now !== tod(1, 2, 4, 5)) $display("FAIL simul_pending: got %h exp %h", t_now, tod(1, 2, 4, 5)); else n_pass++;
    endtask

    task automatic test_holdover_expiry();
        bit seen;
        int cyc;
        for (int i = 1; i <= 9; i++) begin
            wait_tick(1100, seen, cyc);
            n_checks++; if (!seen || time_valid !== 1'b1 || holdover !== 1'b1)
                $display("FAIL expiry_tick_%0d: got seen=%b tv=%b ho=%b exp 1 1 1", i, seen, time_valid, holdover); else n_pass++;
        end
        n_checks++; if (t_now !== tod(1, 2, 13, 5)) $display("FAIL expiry_time: got %h exp %h", t_now, tod(1, 2, 13, 5)); else n_pass++;
        step(1);
        n_checks++; if (time_valid !== 1'b0 || holdover !== 1'b0)
            $display("FAIL expiry_drop: got tv=%b ho=%b exp tv=0 ho=0", time_valid, holdover); else n_pass++;
        pulse_pps();
        n_checks++; if (tick !== 1'b0) $display("FAIL unsync_pps: got tick=%b exp 0", tick); else n_pass++;
        wait_tick(1100, seen, cyc);
        n_checks++; if (seen) $display("FAIL unsync_no_tick: got tick after %0d cycles exp none", cyc); else n_pass++;
    endtask

    task automatic test_day_wrap();
        leap_year = 1'b0;
        send_frame(59, 59, 23, 365);
        n_checks++; if (bad_frame !== 1'b0) $display("FAIL wrap_frame_ok: got bad=%b exp 0", bad_frame); else n_pass++;
        pulse_pps();
        n_checks++; if (t_now !== tod(0, 0, 0, 1) || time_valid !== 1'b1)
            $display("FAIL wrap_365: got t=%h tv=%b exp t=%h tv=1", t_now, time_valid, tod(0, 0, 0, 1)); else n_pass++;
        leap_year = 1'b1;
        send_frame(59, 59, 23, 365);
        n_checks++; if (mismatch !== 1'b1) $display("FAIL wrap_leap_mm: got %b exp 1", mismatch); else n_pass++;
        wait_subsec(999);
        pulse_pps();
        n_checks++; if (t_now !== tod(0, 0, 0, 366)) $display("FAIL wrap_366: got %h exp %h", t_now, tod(0, 0, 0, 366)); else n_pass++;
        send_frame(58, 59, 23, 366);
        n_checks++; if (bad_frame !== 1'b0 || mismatch !== 1'b1)
            $display("FAIL leap_day366_frame: got bad=%b mm=%b exp bad=0 mm=1", bad_frame, mismatch); else n_pass++;
        wait_subsec(999);
        pulse_pps();
        n_checks++; if (t_now !== tod(23, 59, 59, 366)) $display("FAIL leap_preload: got %h exp %h", t_now, tod(23, 59, 59, 366)); else n_pass++;
        wait_subsec(999);
        pulse_pps();
        n_checks++; if (t_now !== tod(0, 0, 0, 1)) $display("FAIL running_year_wrap: got %h exp %h", t_now, tod(0, 0, 0, 1)); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_first_lock();
        test_pps_window();
        test_holdover_recover();
        test_mismatch();
        test_bad_frame();
        test_simultaneous();
        test_holdover_expiry();
        test_day_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
